// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states and access-legality helpers.
// Pure declarations; no latency or backpressure of its own.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } lsu_state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Stores share the load codes for B/H/W, so one check covers both directions.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data, and merges sub-word store data into a word.
// Purely combinational (zero latency); no handshake, so no backpressure.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = mem_word_i >> {byte_off_i, 3'b000};
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data_o = shifted;
      F3_BU:   load_data_o = {24'd0, shifted[7:0]};
      F3_HU:   load_data_o = {16'd0, shifted[15:0]};
      default: load_data_o = '0;
    endcase
  end

  always_comb begin
    merged_o = mem_word_i;
    case (funct3_i)
      F3_B:    merged_o[{byte_off_i, 3'b000} +: 8]        = wdata_i[7:0];
      F3_H:    merged_o[{byte_off_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: loads and SW respond 1 cycle after accept, SB/SH read-modify-write in 2.
// A held response (resp_ready_i=0) blocks new requests; req_ready_o reopens as the response drains.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_fault_o,
  output logic                  mem_read_en_o,
  output logic                  mem_write_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_write_data_o,
  input  logic [31:0]           mem_read_data_i
);

  lsu_state_t            state_q, state_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_fault_q, resp_fault_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;

  logic [31:0]           load_data;
  logic [31:0]           merged;
  logic                  accept;
  logic                  req_fault;
  logic                  is_sw;
  logic [ADDR_WIDTH-1:0] req_word_addr;

  assign req_word_addr = req_addr_i[ADDR_WIDTH+1:2];
  assign is_sw         = req_we_i && (req_funct3_i == F3_W);
  assign req_fault     = !f3_legal(req_we_i, req_funct3_i)
                       || f3_misaligned(req_funct3_i, req_addr_i[1:0])
                       || (req_addr_i[31:ADDR_WIDTH+2] != '0);
  assign accept        = req_valid_i && req_ready_o;

  lsu_lane_align u_lane_align (
    .funct3_i    (req_funct3_i),
    .byte_off_i  (req_addr_i[1:0]),
    .mem_word_i  (mem_read_data_i),
    .wdata_i     (req_wdata_i),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          resp_fault_d = req_fault;
          resp_rdata_d = (req_fault || req_we_i) ? 32'd0 : load_data;
          if (!req_fault && req_we_i && !is_sw) begin
            state_d   = WRITE;
            wr_addr_d = req_word_addr;
            wr_data_d = merged;
          end else begin
            state_d = RESP;
          end
        end else if (state_q == RESP && resp_ready_i) begin
          state_d = IDLE;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Enables are gated by reset so a reset edge can never land a memory write.
  always_comb begin
    req_ready_o      = (state_q == IDLE) || (state_q == RESP && resp_ready_i);
    resp_valid_o     = (state_q == RESP);
    resp_rdata_o     = resp_rdata_q;
    resp_fault_o     = resp_fault_q;
    mem_read_en_o    = rst_n_i && accept && !req_fault && !is_sw;
    mem_write_en_o   = rst_n_i && ((accept && !req_fault && is_sw) || state_q == WRITE);
    mem_addr_o       = (state_q == WRITE) ? wr_addr_q : req_word_addr;
    mem_write_data_o = (state_q == WRITE) ? wr_data_q : req_wdata_i;
  end

endmodule
